// File: rtl/fetch_queue_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, Execute redirect
// and the decode-side head entry with its split ISA fields.
interface fetch_queue_unit_if #(
  parameter int unsigned PC_W = 32
);
  logic            imem_req_valid;
  logic [PC_W-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;

  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_instr;
  logic [PC_W-1:0] dec_pc;
  logic [PC_W-1:0] dec_pc_plus4;
  logic [1:0]      dec_cond;
  logic [1:0]      dec_tipo;
  logic [2:0]      dec_opcode;
  logic [3:0]      dec_rd;
  logic [3:0]      dec_rn;
  logic [1:0]      dec_flag_mov_shift;
  logic            dec_flag_mem_index;
  logic [13:0]     dec_operando2;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output dec_valid, dec_instr, dec_pc, dec_pc_plus4,
    output dec_cond, dec_tipo, dec_opcode, dec_rd, dec_rn,
    output dec_flag_mov_shift, dec_flag_mem_index, dec_operando2,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  dec_valid, dec_instr, dec_pc, dec_pc_plus4,
    input  dec_cond, dec_tipo, dec_opcode, dec_rd, dec_rn,
    input  dec_flag_mov_shift, dec_flag_mem_index, dec_operando2,
    output dec_ready
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Credit-based sequential fetch with a DEPTH-entry prefetch queue and redirect flush.
// Define FETCH_STATS_EN to add saturating stat_fetched / stat_flushed counters.
module fetch_queue_unit #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  fetch_queue_unit_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_flushed
`endif
);

  localparam int unsigned     AW      = $clog2(DEPTH);
  localparam int unsigned     CW      = AW + 1;
  localparam int unsigned     CW1     = CW + 1;
  localparam logic [CW:0]     DEPTH_W = CW1'(DEPTH);
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] resp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;

  logic [31:0]     q_instr [DEPTH];
  logic [PC_W-1:0] q_pc    [DEPTH];

  logic [CW:0]     credit_used;
  logic            req_valid;
  logic            req_fire;
  logic            rsp_acc;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic            head_valid;
  logic [31:0]     head_instr;
  logic [PC_W-1:0] head_pc;
  logic [PC_W-1:0] head_pc_plus4;

  always_comb begin
    credit_used   = {1'b0, count} + {1'b0, outstanding};
    head_valid    = (count != '0);
    // Gating with rst keeps the request low for the whole reset window.
    req_valid     = rst && !bus.redirect_valid && (credit_used < DEPTH_W);
    req_fire      = req_valid && bus.imem_req_ready;
    rsp_acc       = bus.imem_rsp_valid && (outstanding != '0);
    rsp_drop      = rsp_acc && (drop_cnt != '0);
    push          = rsp_acc && !rsp_drop && !bus.redirect_valid;
    pop           = head_valid && bus.dec_ready && !bus.redirect_valid;
    head_instr    = head_valid ? q_instr[head] : '0;
    head_pc       = head_valid ? q_pc[head] : '0;
    head_pc_plus4 = head_valid ? (q_pc[head] + PC_STEP) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      head        <= '0;
      tail        <= '0;
    end else if (bus.redirect_valid) begin
      // Everything still in flight belongs to the old path; a response landing
      // in this very cycle is already retired here, so it is not re-counted.
      fetch_pc    <= bus.redirect_pc;
      resp_pc     <= bus.redirect_pc;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      outstanding <= outstanding - CW'(rsp_acc);
      drop_cnt    <= outstanding - CW'(rsp_acc);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_acc);
      if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
      if (push) begin
        resp_pc <= resp_pc + PC_STEP;
        tail    <= tail + AW'(1);
      end
      if (pop) head <= head + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail] <= bus.imem_rsp_data;
      q_pc[tail]    <= resp_pc;
    end
  end

  assign bus.imem_req_valid     = req_valid;
  assign bus.imem_req_addr      = fetch_pc;
  assign bus.dec_valid          = head_valid;
  assign bus.dec_instr          = head_instr;
  assign bus.dec_pc             = head_pc;
  assign bus.dec_pc_plus4       = head_pc_plus4;
  assign bus.dec_cond           = head_instr[31:30];
  assign bus.dec_tipo           = head_instr[29:28];
  assign bus.dec_opcode         = head_instr[27:25];
  assign bus.dec_rd             = head_instr[24:21];
  assign bus.dec_rn             = head_instr[20:17];
  assign bus.dec_flag_mov_shift = head_instr[16:15];
  assign bus.dec_flag_mem_index = head_instr[14];
  assign bus.dec_operando2      = head_instr[13:0];

`ifdef FETCH_STATS_EN
  logic [CW:0] flush_amt;
  logic [32:0] flushed_sum;

  always_comb begin
    flush_amt   = bus.redirect_valid ? ({1'b0, count} + CW1'(rsp_acc)) : CW1'(rsp_drop);
    flushed_sum = {1'b0, stat_flushed} + 33'(flush_amt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      if (pop && (stat_fetched != '1)) stat_fetched <= stat_fetched + 32'd1;
      stat_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end
`endif

endmodule
